// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//   Registered 32-bit integer ALU for the single-cycle ARM-LP (LEGv8-subset)
//   datapath. Operands come from operand preparation (register file or
//   sign-extended immediate); the operation code comes from the controller.
//   The result feeds the data-cache address / write-back path, and the zero
//   flag feeds the PC unit for CBZ branches.
//
// Ports
//   clock           in   1   rising-edge processor clock
//   resetN          in   1   asynchronous active-low reset
//   readData1       in  32   operand A
//   readData2       in  32   operand B
//   aluControlCode  in   4   operation select
//   result          out 32   registered operation result
//   zeroFlag        out  1   registered, 1 when result == 0
//   carryBit        out  1   registered carry (ADD) / no-borrow (SUB) flag
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu (
  input  logic        clock,
  input  logic        resetN,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic [3:0]  aluControlCode,
  output logic [31:0] result,
  output logic        zeroFlag,
  output logic        carryBit
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_OR   = 4'd4,
    OP_NOR  = 4'd5,
    OP_AND  = 4'd6,
    OP_CBZ  = 4'd7,
    OP_XOR  = 4'd9,
    OP_LSL  = 4'd10,
    OP_LSR  = 4'd11,
    OP_NAND = 4'd12,
    OP_MOV  = 4'd13
  } alu_op_e;

  alu_op_e     w_op;
  logic [4:0]  w_shamt;
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic [31:0] w_result;
  logic        w_carry;

  logic [31:0] r_result;
  logic        r_zero;
  logic        r_carry;

  assign w_op    = alu_op_e'(aluControlCode);
  assign w_shamt = readData2[4:0];

  // Both arithmetic paths are 33 bits wide so bit 32 is the carry out.
  // Subtraction is A + ~B + 1: bit 32 is set exactly when no borrow occurs
  // (A >= B unsigned), which is the ARM carry convention.
  assign w_sum  = {1'b0, readData1} + {1'b0, readData2};
  assign w_diff = {1'b0, readData1} + {1'b0, ~readData2} + 33'd1;

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    // Unlisted codes therefore yield result 0 and carry 0.
    w_result = '0;
    w_carry  = 1'b0;
    case (w_op)
      OP_ADD:  {w_carry, w_result} = w_sum;
      OP_SUB:  {w_carry, w_result} = w_diff;
      OP_OR:   w_result = readData1 | readData2;
      OP_NOR:  w_result = ~(readData1 | readData2);
      OP_AND:  w_result = readData1 & readData2;
      OP_CBZ:  w_result = readData2;
      OP_XOR:  w_result = readData1 ^ readData2;
      OP_LSL:  w_result = readData1 << w_shamt;
      OP_LSR:  w_result = readData1 >> w_shamt;
      OP_NAND: w_result = ~(readData1 & readData2);
      OP_MOV:  w_result = readData2;
      default: begin
        w_result = '0;
        w_carry  = 1'b0;
      end
    endcase
  end

  // The zero flag is derived from the same value being registered into
  // result, so the two can never disagree.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state.
      r_result <= w_result;
      r_zero   <= (w_result == 32'd0);
      r_carry  <= w_carry;
    end
  end

  assign result   = r_result;
  assign zeroFlag = r_zero;
  assign carryBit = r_carry;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//   Directed-vector bench for alu. Inputs are driven on the falling edge,
//   outputs sampled 1 ns after the rising edge. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alu;

  logic        clock = 1'b0;
  logic        resetN;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [3:0]  aluControlCode;
  logic [31:0] result;
  logic        zeroFlag;
  logic        carryBit;

  int n_vectors     = 0;
  int n_miscompares = 0;

  alu dut (
    .clock          (clock),
    .resetN         (resetN),
    .readData1      (readData1),
    .readData2      (readData2),
    .aluControlCode (aluControlCode),
    .result         (result),
    .zeroFlag       (zeroFlag),
    .carryBit       (carryBit)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_r,
                           input logic exp_z, input logic exp_c);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_zero"},   {31'd0, zeroFlag}, {31'd0, exp_z});
    check({tag, "_carry"},  {31'd0, carryBit}, {31'd0, exp_c});
  endtask

  // Drive one operation on the falling edge, capture on the next rising edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] code, input logic [31:0] exp_r,
                        input logic exp_z, input logic exp_c);
    @(negedge clock);
    readData1      = a;
    readData2      = b;
    aluControlCode = code;
    @(posedge clock);
    #1;
    check_out(tag, exp_r, exp_z, exp_c);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset with ADD 15+15 pending and the clock running.
    resetN         = 1'b0;
    readData1      = 32'd15;
    readData2      = 32'd15;
    aluControlCode = 4'd2;
    repeat (2) @(posedge clock);
    #1;
    check_out("reset", 32'd0, 1'b1, 1'b0);

    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
    check_out("first_add", 32'd30, 1'b0, 1'b0);

    // Arithmetic sequence
    run_op("cbz_15",   32'd15, 32'd15, 4'd7, 32'd15,         1'b0, 1'b0);
    run_op("sub_10_15",32'd10, 32'd15, 4'd3, 32'hFFFF_FFFB,  1'b0, 1'b0);
    run_op("sub_15_10",32'd15, 32'd10, 4'd3, 32'd5,          1'b0, 1'b1);
    run_op("sub_eq",   32'd10, 32'd10, 4'd3, 32'd0,          1'b1, 1'b1);

    // Logic sequence
    run_op("and",  32'd5, 32'd15, 4'd6,  32'd5,         1'b0, 1'b0);
    run_op("or",   32'd5, 32'd15, 4'd4,  32'd15,        1'b0, 1'b0);
    run_op("xor",  32'd5, 32'd10, 4'd9,  32'd15,        1'b0, 1'b0);
    run_op("nor",  32'd5, 32'd10, 4'd5,  32'hFFFF_FFF0, 1'b0, 1'b0);
    run_op("nand", 32'd5, 32'd10, 4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mov",  32'd5, 32'd10, 4'd13, 32'd10,        1'b0, 1'b0);

    // Carry and wrap-around
    run_op("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'd2, 32'd0,         1'b1, 1'b1);
    run_op("sub_max",  32'hFFFF_FFFF, 32'd1, 4'd3, 32'hFFFF_FFFE, 1'b0, 1'b1);
    run_op("sub_0_1",  32'd0,         32'd1, 4'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Shifts: only B[4:0] is used
    run_op("lsl_21",   32'h8000_0001, 32'h21, 4'd10, 32'h0000_0002, 1'b0, 1'b0);
    run_op("lsr_21",   32'h8000_0001, 32'h21, 4'd11, 32'h4000_0000, 1'b0, 1'b0);
    run_op("lsl_20",   32'h8000_0001, 32'h20, 4'd10, 32'h8000_0001, 1'b0, 1'b0);
    run_op("lsr_1f",   32'h8000_0001, 32'h1F, 4'd11, 32'h0000_0001, 1'b0, 1'b0);

    // CBZ zero and undefined codes
    run_op("cbz_0",  32'd7,  32'd0, 4'd7,  32'd0, 1'b1, 1'b0);
    run_op("undef15",32'hFFFF_FFFF, 32'd1, 4'd15, 32'd0, 1'b1, 1'b0);
    run_op("add_c",  32'hFFFF_FFFF, 32'd2, 4'd2,  32'd1, 1'b0, 1'b1);
    run_op("undef0", 32'hFFFF_FFFF, 32'd2, 4'd0,  32'd0, 1'b1, 1'b0);
    run_op("undef8", 32'd3, 32'd4, 4'd8,  32'd0, 1'b1, 1'b0);
    run_op("undef14",32'd3, 32'd4, 4'd14, 32'd0, 1'b1, 1'b0);

    // Latency: change the code between edges; outputs hold until the edge.
    run_op("lat_add", 32'd20, 32'd22, 4'd2, 32'd42, 1'b0, 1'b0);
    @(negedge clock);
    aluControlCode = 4'd3;
    readData1      = 32'd50;
    readData2      = 32'd8;
    #4;
    check_out("lat_hold", 32'd42, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_out("lat_new", 32'd42, 1'b0, 1'b1);

    // Reset asserted between edges clears outputs at once and discards
    // the pending operation.
    run_op("pre_rst", 32'd1, 32'd1, 4'd2, 32'd2, 1'b0, 1'b0);
    @(negedge clock);
    readData1      = 32'hFFFF_FFFF;
    readData2      = 32'd1;
    aluControlCode = 4'd2;
    resetN         = 1'b0;
    #1;
    check_out("async_rst", 32'd0, 1'b1, 1'b0);
    @(posedge clock);
    #1;
    check_out("rst_hold", 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    resetN = 1'b1;
    readData1 = 32'd9;
    readData2 = 32'd4;
    aluControlCode = 4'd11;
    @(posedge clock);
    #1;
    check_out("post_rst", 32'd0, 1'b1, 1'b0);
    run_op("post_rst2", 32'd9, 32'd1, 4'd11, 32'd4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 32-bit integer ALU for the single-cycle ARM-LP (LEGv8-subset) datapath. It takes two operands from operand preparation (register file or sign-extended immediate) and a 4-bit operation code from the controller. It returns a 32-bit result, used as the data-cache address or write-back value, plus zero and carry flags; the PC unit consumes the zero flag for CBZ branches.

## Interface
Clocking: one clock; reset is asynchronous and active-low.
- Parameters: none (datapath fixed at 32 bits, opcode at 4 bits)
- clock  input  1  rising-edge clock, shared processor clock
- resetN  input  1  asynchronous active-low reset
- readData1  input  32  operand A
- readData2  input  32  operand B
- aluControlCode  input  4  operation select (see Operation)
- result  output  32  registered operation result
- zeroFlag  output  1  registered; 1 when result == 0
- carryBit  output  1  registered carry / no-borrow flag

## Operation
- Operation codes (A = readData1, B = readData2, all unsigned 32-bit, result truncated to 32 bits):
  - 2 ADD: A + B; carry = bit 32 of the 33-bit sum
  - 3 SUB: A − B (A + ~B + 1); carry = 1 when no borrow (A ≥ B unsigned), ARM convention
  - 4 OR: A | B
  - 5 NOR: ~(A | B)
  - 6 AND: A & B
  - 7 CBZ/pass-B: result = B, so zeroFlag = (B == 0)
  - 9 XOR: A ^ B
  - 10 LSL: A << B[4:0]
  - 11 LSR: A >> B[4:0], logical (zero fill)
  - 12 NAND: ~(A & B)
  - 13 MOV: result = B
  - all other codes (0, 1, 8, 14, 15): result = 0; zeroFlag therefore 1
- zeroFlag = (next result == 0) for every code, computed from the same value that is registered into result.
- carryBit is defined only for ADD and SUB. Every other code writes carryBit = 0.
- Shifts use only B[4:0]; B[31:5] is ignored. A shift of 0 returns A unchanged.
- No internal state beyond the three output registers. There is no overflow or negative flag.

## Timing
- Combinational compute; result, zeroFlag and carryBit are all captured on the same rising clock edge.
- Latency: 1 cycle. Operands and code applied before edge N appear on the outputs after edge N and hold until edge N+1.
- Inputs may change at any time between edges; only values at the rising edge matter.
- Reset: on resetN falling, asynchronously result = 0, zeroFlag = 1, carryBit = 0. These values hold while resetN = 0.
- First rising edge with resetN = 1 captures a normal operation.
- Reset asserted mid-operation discards the pending computation; no partial update.
- Back-to-back operations are allowed every cycle with no handshake or stall.

## Test plan
- Reset: assert resetN = 0 with A = 15, B = 15, code 2, and clock running -> result 0, zeroFlag 1, carryBit 0. Release reset -> after next edge result 30, zeroFlag 0, carryBit 0.
- Arithmetic sequence, one edge per step:
  - A = 15, B = 15, code 7 -> result 15, zero 0
  - A = 10, code 3 -> result 0xFFFFFFFB, carry 0
  - A = 15, B = 10, code 3 -> result 5, carry 1
  - A = 10, B = 10, code 3 -> result 0, zero 1, carry 1
- Logic sequence:
  - A = 5, B = 15: code 6 -> 5; code 4 -> 15
  - A = 5, B = 10: code 9 -> 15; code 5 -> 0xFFFFFFF0; code 12 -> 0xFFFFFFFF; code 13 -> 10
  - carry 0 throughout
- Carry and wrap-around: A = 0xFFFFFFFF, B = 1, code 2 -> result 0, zero 1, carry 1. Same operands, code 3 -> 0xFFFFFFFE, carry 1.
- Shifts and CBZ zero:
  - A = 0x80000001, B = 0x21, code 10 -> 0x00000002; code 11 -> 0x40000000
  - B = 0, code 7 -> result 0, zero 1
  - undefined code 15 -> result 0, zero 1, carry 0
- Latency check: change the code between edges, then sample just before the next edge -> outputs still show the previous operation's values.
